// File: rtl/mac_pkg.sv
// rtl/mac_pkg.sv - shared Ethernet MAC constants and receive state encodings
//
// Purpose: CRC-32 polynomial/seed, frame size defaults, preamble/SFD bytes,
// receive FSM state encodings and a bit-reverse helper used by the FCS check.
// Ports: none (package).

package mac_pkg;

  localparam logic [31:0] CRC_POLY      = 32'h04C11DB7;
  localparam logic [31:0] CRC_SEED      = 32'hFFFFFFFF;
  localparam int          MIN_SIZE_DEF  = 64;
  localparam int          MAX_SIZE_DEF  = 1518;
  localparam logic [7:0]  PREAMBLE_BYTE = 8'h55;
  localparam logic [7:0]  SFD_BYTE      = 8'hD5;

  typedef enum logic [2:0] {
    ST_WAIT,
    ST_IDLE,
    ST_PREAMBLE,
    ST_DATA,
    ST_CHECK
  } rx_state_t;

  function automatic logic [31:0] bitrev32(input logic [31:0] v);
    logic [31:0] r;
    for (int i = 0; i < 32; i++) begin
      r[i] = v[31-i];
    end
    return r;
  endfunction

endpackage

// File: rtl/crc.sv
// rtl/crc.sv - parallel CRC register, data bits consumed LSB first
//
// Purpose: shift-left CRC with configurable polynomial and seed; one data
// word per enabled cycle. Feeding bit 0 first makes the register equivalent
// to the reflected Ethernet CRC once bit-reversed.
// Ports:
//   clock, reset      clock and asynchronous active-high reset
//   init_i            reload seed (priority over en_i)
//   en_i              fold data_i into the register
//   data_i            data word
//   crc_o             current register value

module crc
  import mac_pkg::*;
#(
  parameter int                   DATA_WIDTH = 8,
  parameter int                   CRC_WIDTH  = 32,
  parameter logic [CRC_WIDTH-1:0] POLY       = CRC_POLY,
  parameter logic [CRC_WIDTH-1:0] SEED       = CRC_SEED
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic                  init_i,
  input  logic                  en_i,
  input  logic [DATA_WIDTH-1:0] data_i,
  output logic [CRC_WIDTH-1:0]  crc_o
);

  logic [CRC_WIDTH-1:0] crc_q;
  logic [CRC_WIDTH-1:0] crc_d;

  always_comb begin
    crc_d = crc_q;
    for (int i = 0; i < DATA_WIDTH; i++) begin
      if (crc_d[CRC_WIDTH-1] ^ data_i[i]) begin
        crc_d = {crc_d[CRC_WIDTH-2:0], 1'b0} ^ POLY;
      end else begin
        crc_d = {crc_d[CRC_WIDTH-2:0], 1'b0};
      end
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      crc_q <= SEED;
    end else if (init_i) begin
      crc_q <= SEED;
    end else if (en_i) begin
      crc_q <= crc_d;
    end
  end

  assign crc_o = crc_q;

endmodule

// File: rtl/rx_sm.sv
// rtl/rx_sm.sv - Ethernet MAC receive state machine (PHY byte stream to RX FIFO)
//
// Purpose: strips preamble/SFD, delays payload by four bytes so the FCS never
// reaches the FIFO, writes payload, then checks CRC, length, PHY error and
// overflow and issues one fifo_frame_good or fifo_frame_bad pulse per frame.
// Optional feature macro: RX_ADDR_FILTER_EN (destination address filter).
// Ports:
//   clock, reset                       clock, asynchronous active-high reset
//   rx_data_valid, rx_data, rx_error   PHY receive interface (RX_DV/RXD/RX_ER)
//   fifo_full                          FIFO cannot accept a write this cycle
//   fifo_data, fifo_data_write         FIFO byte and write strobe
//   fifo_data_start                    first byte of frame (with write)
//   fifo_frame_good, fifo_frame_bad    one-cycle commit / discard pulses

module rx_sm
  import mac_pkg::*;
#(
  parameter logic [47:0] MAC_ADDRESS = 48'h000000000000,
  parameter int          MIN_SIZE    = MIN_SIZE_DEF,
  parameter int          MAX_SIZE    = MAX_SIZE_DEF
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       rx_data_valid,
  input  logic [7:0] rx_data,
  input  logic       rx_error,
  input  logic       fifo_full,
  output logic [7:0] fifo_data,
  output logic       fifo_data_write,
  output logic       fifo_data_start,
  output logic       fifo_frame_good,
  output logic       fifo_frame_bad
);

  localparam logic [10:0] MIN_LEN = 11'(MIN_SIZE);
  localparam logic [10:0] MAX_LEN = 11'(MAX_SIZE);
  localparam logic [10:0] LEN_SAT = 11'h7FF;

  rx_state_t       state_q;
  logic [3:0][7:0] dl_q;          // delay line, [3] is the oldest byte
  logic [2:0]      fill_q;        // bytes held in the delay line, 0..4
  logic [10:0]     len_q;
  logic            err_q;
  logic            ovf_q;
  logic            first_q;
  logic            good_pend_q;
  logic            bad_pend_q;
  logic [7:0]      data_q;
  logic            wr_q;
  logic            start_q;
  logic            good_q;
  logic            bad_q;

  logic [31:0]     crc_val;
  logic            push;
  logic            sfd_seen;
  logic            wr_req;
  logic            wr_ok;
  logic            addr_reject;
  logic [31:0]     fcs_exp;
  logic            fcs_ok;
  logic            frame_ok;

`ifdef RX_ADDR_FILTER_EN
  logic [39:0] dest_q;            // destination bytes 0-4, byte 0 in [39:32]
  logic [47:0] dest_full;

  assign dest_full   = {dest_q, rx_data};
  assign addr_reject = push && (len_q == 11'd5) &&
                       (dest_full != MAC_ADDRESS) &&
                       (dest_full != 48'hFFFF_FFFF_FFFF);

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      dest_q <= '0;
    end else if (push && (len_q < 11'd5)) begin
      dest_q <= {dest_q[31:0], rx_data};
    end
  end
`else
  logic unused_mac;
  assign unused_mac  = ^MAC_ADDRESS;
  assign addr_reject = 1'b0;
`endif

  always_comb begin
    push     = (state_q == ST_DATA) && rx_data_valid;
    sfd_seen = (state_q == ST_PREAMBLE) && rx_data_valid && (rx_data == SFD_BYTE);
    // A write is due only once the line is full, i.e. the byte leaving it
    // can no longer be part of the FCS.
    wr_req   = push && (fill_q == 3'd4) && !ovf_q && !addr_reject;
    wr_ok    = wr_req && !fifo_full;
    // FCS byte k (k=0 first on the wire) sits in dl_q[3-k].
    fcs_exp  = ~bitrev32(crc_val);
    fcs_ok   = (fill_q == 3'd4) && ({dl_q[0], dl_q[1], dl_q[2], dl_q[3]} == fcs_exp);
    frame_ok = fcs_ok && (len_q >= MIN_LEN) && (len_q <= MAX_LEN) && !err_q && !ovf_q;
  end

  crc #(
    .DATA_WIDTH (8),
    .CRC_WIDTH  (32),
    .POLY       (CRC_POLY),
    .SEED       (CRC_SEED)
  ) u_crc (
    .clock  (clock),
    .reset  (reset),
    .init_i (sfd_seen),
    .en_i   (wr_ok),
    .data_i (dl_q[3]),
    .crc_o  (crc_val)
  );

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q     <= ST_WAIT;
      dl_q        <= '0;
      fill_q      <= '0;
      len_q       <= '0;
      err_q       <= 1'b0;
      ovf_q       <= 1'b0;
      first_q     <= 1'b0;
      good_pend_q <= 1'b0;
      bad_pend_q  <= 1'b0;
      data_q      <= '0;
      wr_q        <= 1'b0;
      start_q     <= 1'b0;
      good_q      <= 1'b0;
      bad_q       <= 1'b0;
    end else begin
      wr_q        <= 1'b0;
      start_q     <= 1'b0;
      // Verdict decided in CHECK is presented one cycle later.
      good_q      <= good_pend_q;
      bad_q       <= bad_pend_q;
      good_pend_q <= 1'b0;
      bad_pend_q  <= 1'b0;
      case (state_q)
        ST_WAIT: begin
          if (!rx_data_valid) state_q <= ST_IDLE;
        end
        ST_IDLE: begin
          if (rx_data_valid) begin
            state_q <= (rx_data == PREAMBLE_BYTE) ? ST_PREAMBLE : ST_WAIT;
          end
        end
        ST_PREAMBLE: begin
          if (!rx_data_valid) begin
            state_q <= ST_IDLE;
          end else if (rx_data == SFD_BYTE) begin
            state_q <= ST_DATA;
            fill_q  <= '0;
            len_q   <= '0;
            err_q   <= 1'b0;
            ovf_q   <= 1'b0;
            first_q <= 1'b1;
          end else if (rx_data != PREAMBLE_BYTE) begin
            state_q <= ST_WAIT;
          end
        end
        ST_DATA: begin
          if (!rx_data_valid) begin
            state_q <= ST_CHECK;
          end else begin
            dl_q <= {dl_q[2:0], rx_data};
            if (fill_q != 3'd4) fill_q <= fill_q + 3'd1;
            if (len_q != LEN_SAT) len_q <= len_q + 11'd1;
            if (rx_error) err_q <= 1'b1;
            if (wr_req && fifo_full) ovf_q <= 1'b1;
            if (wr_ok) begin
              data_q  <= dl_q[3];
              wr_q    <= 1'b1;
              start_q <= first_q;
              first_q <= 1'b0;
            end
            // Rejected frame: discard now and ignore the rest of it.
            if (addr_reject) begin
              bad_q   <= 1'b1;
              state_q <= ST_WAIT;
            end
          end
        end
        ST_CHECK: begin
          good_pend_q <= frame_ok;
          bad_pend_q  <= !frame_ok;
          state_q     <= ST_IDLE;
        end
        default: state_q <= ST_WAIT;
      endcase
    end
  end

  assign fifo_data       = data_q;
  assign fifo_data_write = wr_q;
  assign fifo_data_start = start_q;
  assign fifo_frame_good = good_q;
  assign fifo_frame_bad  = bad_q;

endmodule

// File: tb/tb_rx_sm.sv
// tb/tb_rx_sm.sv - self-checking bench for rx_sm (frame table plus corner sequences)

module tb_rx_sm;

  localparam logic [47:0] TB_MAC = 48'h02_00_00_00_00_01;

  logic       clock = 1'b0;
  logic       reset = 1'b1;
  logic       rx_data_valid = 1'b0;
  logic [7:0] rx_data = 8'h00;
  logic       rx_error = 1'b0;
  logic       fifo_full = 1'b0;
  logic [7:0] fifo_data;
  logic       fifo_data_write;
  logic       fifo_data_start;
  logic       fifo_frame_good;
  logic       fifo_frame_bad;

  always #5 clock = ~clock;

  rx_sm #(
    .MAC_ADDRESS (TB_MAC),
    .MIN_SIZE    (64),
    .MAX_SIZE    (1518)
  ) dut (
    .clock           (clock),
    .reset           (reset),
    .rx_data_valid   (rx_data_valid),
    .rx_data         (rx_data),
    .rx_error        (rx_error),
    .fifo_full       (fifo_full),
    .fifo_data       (fifo_data),
    .fifo_data_write (fifo_data_write),
    .fifo_data_start (fifo_data_start),
    .fifo_frame_good (fifo_frame_good),
    .fifo_frame_bad  (fifo_frame_bad)
  );

  int cyc = 0;
  always @(posedge clock) cyc <= cyc + 1;

  // Monitor: collects everything the DUT emits, sampled on the falling edge.
  logic [7:0] wq[$];
  int         wr_cyc[$];
  int         start_idx[$];
  int         good_cnt = 0;
  int         bad_cnt = 0;
  int         both_cnt = 0;
  int         last_pulse_cyc = -1;

  always @(negedge clock) begin
    if (fifo_data_write) begin
      if (fifo_data_start) start_idx.push_back(wq.size());
      wq.push_back(fifo_data);
      wr_cyc.push_back(cyc);
    end
    if (fifo_frame_good && fifo_frame_bad) both_cnt++;
    if (fifo_frame_good) begin
      good_cnt++;
      last_pulse_cyc = cyc;
    end
    if (fifo_frame_bad) begin
      bad_cnt++;
      last_pulse_cyc = cyc;
    end
  end

  int n_tests = 0;
  int n_fail = 0;

  task automatic check(input string name, input int act, input int exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  typedef struct {
    string       name;
    int          plen;      // bytes before the FCS
    bit          corrupt;
    int          err_idx;
    int          full_idx;
    logic [47:0] dest;
    int          exp_wr;
    int          exp_good;
    int          exp_bad;
    bit          reject;
  } frame_t;

  frame_t     tbl[$];
  logic [7:0] frame_q[$];
  int         t0;
  int         drop_cyc;

  function automatic frame_t mk(input string name, input int plen, input bit corrupt,
                                input int err_idx, input int full_idx, input logic [47:0] dest,
                                input int exp_wr, input int exp_good, input int exp_bad,
                                input bit reject);
    frame_t f;
    f.name = name; f.plen = plen; f.corrupt = corrupt; f.err_idx = err_idx;
    f.full_idx = full_idx; f.dest = dest; f.exp_wr = exp_wr; f.exp_good = exp_good;
    f.exp_bad = exp_bad; f.reject = reject;
    return f;
  endfunction

  // Reference FCS uses the reflected CRC-32 formulation.
  task automatic build(input frame_t f);
    logic [31:0] c;
    logic [7:0]  b;
    frame_q.delete();
    c = 32'hFFFFFFFF;
    for (int j = 0; j < f.plen; j++) begin
      if (j < 6) b = f.dest[47-8*j -: 8];
      else       b = 8'((j * 13 + f.plen) & 255);
      frame_q.push_back(b);
      c = c ^ {24'h0, b};
      for (int k = 0; k < 8; k++) c = c[0] ? ((c >> 1) ^ 32'hEDB88320) : (c >> 1);
    end
    c = ~c;
    for (int k = 0; k < 4; k++) begin
      b = c[8*k +: 8];
      if (f.corrupt && k == 1) b = b ^ 8'h08;
      frame_q.push_back(b);
    end
  endtask

  task automatic drive(input logic v, input logic [7:0] d, input logic e, input logic full);
    @(posedge clock);
    #1;
    rx_data_valid = v;
    rx_data       = d;
    rx_error      = e;
    fifo_full     = full;
  endtask

  task automatic send(input frame_t f, input int gap);
    build(f);
    for (int i = 0; i < 7; i++) drive(1'b1, 8'h55, 1'b0, 1'b0);
    drive(1'b1, 8'hD5, 1'b0, 1'b0);
    for (int i = 0; i < frame_q.size(); i++) begin
      drive(1'b1, frame_q[i], 1'(i == f.err_idx), 1'(i == f.full_idx));
      if (i == 0) t0 = cyc;
    end
    drive(1'b0, 8'h00, 1'b0, 1'b0);
    drop_cyc = cyc;
    for (int i = 1; i < gap; i++) drive(1'b0, 8'h00, 1'b0, 1'b0);
  endtask

  task automatic run_entry(input frame_t f);
    int bw, bs, bg, bb, mism;
    bw = wq.size(); bs = start_idx.size(); bg = good_cnt; bb = bad_cnt;
    send(f, 8);
    check({f.name, "_writes"}, wq.size() - bw, f.exp_wr);
    check({f.name, "_good"}, good_cnt - bg, f.exp_good);
    check({f.name, "_bad"}, bad_cnt - bb, f.exp_bad);
    if (f.exp_wr > 0) begin
      check({f.name, "_starts"}, start_idx.size() - bs, 1);
      if (start_idx.size() > bs) check({f.name, "_start_pos"}, start_idx[bs], bw);
      if (wq.size() > bw) check({f.name, "_first_wr_cyc"}, wr_cyc[bw], t0 + 5);
      mism = 0;
      for (int j = 0; j < f.exp_wr && (bw + j) < wq.size(); j++) begin
        if (wq[bw+j] !== frame_q[j]) mism++;
      end
      check({f.name, "_data_mism"}, mism, 0);
    end
    check({f.name, "_pulse_cyc"}, last_pulse_cyc, f.reject ? (t0 + 6) : (drop_cyc + 3));
  endtask

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    int bw, bg, bb, bw_rel;
    frame_t f;

    tbl.push_back(mk("good64",   60,   1'b0, -1, -1, TB_MAC, 60,   1, 0, 1'b0));
    tbl.push_back(mk("badfcs",   60,   1'b1, -1, -1, TB_MAC, 60,   0, 1, 1'b0));
    tbl.push_back(mk("runt40",   36,   1'b0, -1, -1, TB_MAC, 36,   0, 1, 1'b0));
    tbl.push_back(mk("len63",    59,   1'b0, -1, -1, TB_MAC, 59,   0, 1, 1'b0));
    tbl.push_back(mk("max1518",  1514, 1'b0, -1, -1, TB_MAC, 1514, 1, 0, 1'b0));
    tbl.push_back(mk("long1519", 1515, 1'b0, -1, -1, TB_MAC, 1515, 0, 1, 1'b0));
    tbl.push_back(mk("rxerr20",  60,   1'b0, 20, -1, TB_MAC, 60,   0, 1, 1'b0));
    tbl.push_back(mk("ovf30",    60,   1'b0, -1, 30, TB_MAC, 26,   0, 1, 1'b0));
`ifdef RX_ADDR_FILTER_EN
    tbl.push_back(mk("bcast",    60,   1'b0, -1, -1, 48'hFFFF_FFFF_FFFF, 60, 1, 0, 1'b0));
    tbl.push_back(mk("wrongda",  60,   1'b0, -1, -1, 48'h02_00_00_00_00_02, 1, 0, 1, 1'b1));
`endif

    // Reset state.
    repeat (3) @(posedge clock);
    #1;
    check("reset_outputs", int'({fifo_data, fifo_data_write, fifo_data_start,
                                 fifo_frame_good, fifo_frame_bad}), 0);
    reset = 1'b0;
    repeat (3) drive(1'b0, 8'h00, 1'b0, 1'b0);

    foreach (tbl[i]) run_entry(tbl[i]);

    // Shorter than the FCS: no writes, one bad pulse.
    bw = wq.size(); bg = good_cnt; bb = bad_cnt;
    for (int i = 0; i < 7; i++) drive(1'b1, 8'h55, 1'b0, 1'b0);
    drive(1'b1, 8'hD5, 1'b0, 1'b0);
    drive(1'b1, 8'hAA, 1'b0, 1'b0);
    drive(1'b1, 8'hBB, 1'b0, 1'b0);
    drive(1'b1, 8'hCC, 1'b0, 1'b0);
    drive(1'b0, 8'h00, 1'b0, 1'b0);
    drop_cyc = cyc;
    repeat (6) drive(1'b0, 8'h00, 1'b0, 1'b0);
    check("short3_writes", wq.size() - bw, 0);
    check("short3_bad", bad_cnt - bb, 1);
    check("short3_good", good_cnt - bg, 0);
    check("short3_pulse_cyc", last_pulse_cyc, drop_cyc + 3);

    // Abandoned in preamble: no pulse.
    bg = good_cnt; bb = bad_cnt;
    repeat (3) drive(1'b1, 8'h55, 1'b0, 1'b0);
    repeat (6) drive(1'b0, 8'h00, 1'b0, 1'b0);
    check("abandon_pulses", (good_cnt - bg) + (bad_cnt - bb), 0);

    // Back-to-back frames with a single idle cycle.
    bw = wq.size(); bg = good_cnt; bb = bad_cnt;
    send(tbl[0], 1);
    send(tbl[0], 8);
    check("b2b_writes", wq.size() - bw, 120);
    check("b2b_good", good_cnt - bg, 2);
    check("b2b_bad", bad_cnt - bb, 0);

    // Reset mid-frame, released while the frame is still streaming.
    build(tbl[0]);
    bg = good_cnt; bb = bad_cnt; bw_rel = 0;
    for (int i = 0; i < 7; i++) drive(1'b1, 8'h55, 1'b0, 1'b0);
    drive(1'b1, 8'hD5, 1'b0, 1'b0);
    for (int i = 0; i < frame_q.size(); i++) begin
      drive(1'b1, frame_q[i], 1'b0, 1'b0);
      if (i == 35) begin
        #2 reset = 1'b1;
        #1;
        check("rst_async_outputs", int'({fifo_data, fifo_data_write, fifo_data_start,
                                          fifo_frame_good, fifo_frame_bad}), 0);
      end
      if (i == 40) begin
        reset  = 1'b0;
        bw_rel = wq.size();
      end
    end
    repeat (8) drive(1'b0, 8'h00, 1'b0, 1'b0);
    check("rst_mid_writes", wq.size() - bw_rel, 0);
    check("rst_mid_pulses", (good_cnt - bg) + (bad_cnt - bb), 0);
    f = tbl[0];
    f.name = "after_rst";
    run_entry(f);

    check("never_both_pulses", both_cnt, 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/rx_sm.md
# rx_sm

Receive-side state machine of the Ethernet MAC: the counterpart of the transmit state machine. It takes the byte-wide PHY receive stream, strips preamble/SFD, delays data by four bytes so the FCS is never written, and writes payload bytes into the receive FIFO. At frame end it checks CRC, length, PHY error and overflow, then commits or discards the frame with a one-cycle verdict pulse.

## Interface
- MAC_ADDRESS, 48'h000000000000: station address; byte 0 on the wire = [47:40] (used only with filter enabled)
- MIN_SIZE, 64: minimum frame bytes, destination through FCS
- MAX_SIZE, 1518: maximum frame bytes, destination through FCS
- clock  in  1  single clock; all logic on posedge
- reset  in  1  asynchronous, active-high
- rx_data_valid  in  1  PHY receive data valid (RX_DV)
- rx_data  in  8  PHY receive byte
- rx_error  in  1  PHY receive error (RX_ER)
- fifo_full  in  1  FIFO cannot accept a write this cycle
- fifo_data  out  8  byte to FIFO
- fifo_data_write  out  1  write strobe
- fifo_data_start  out  1  marks first byte of frame, qualified by write
- fifo_frame_good  out  1  one-cycle pulse: commit frame
- fifo_frame_bad  out  1  one-cycle pulse: discard bytes since last start

## Operation
- All outputs registered; reset value 0 for every output, state = WAIT.
- WAIT: stay until rx_data_valid=0 sampled, then IDLE. Prevents capturing a frame joined mid-stream, including after reset.
- IDLE: rx_data_valid=1 and rx_data=8'h55 -> PREAMBLE; rx_data_valid=1 with other byte -> WAIT.
- PREAMBLE: 8'h55 stays; 8'hD5 -> DATA, CRC init, length=0, delay line empty; any other byte -> WAIT; rx_data_valid=0 -> IDLE, no pulse.
- DATA: each valid byte enters a 4-byte delay line; length (11 bits, saturate 2047) increments. Once line holds 4 bytes, each new byte pushes the oldest out: written to FIFO and fed to CRC (poly 32'h04C11DB7, seed 32'hFFFFFFFF, 8-bit). First write carries fifo_data_start.
- rx_error=1 on any valid DATA byte sets error flag; reception continues.
- Write required while fifo_full=1: set overflow flag, suppress all further writes for the frame.
- rx_data_valid=0 in DATA -> CHECK. Delay line holds received FCS; byte k must equal (~bitreverse32(crc))[8k+:8], k=0 first received.
- CHECK (one cycle): good iff CRC matches, MIN_SIZE <= length <= MAX_SIZE, no error, no overflow. Pulse fifo_frame_good or fifo_frame_bad; -> IDLE. Frame shorter than 4 bytes: bad pulse.
- Exactly one verdict pulse per frame reaching DATA; never both; never a pulse for frames abandoned in IDLE/PREAMBLE.

## Timing
- Data byte i (0 = first after SFD) sampled at edge E; written (fifo_data_write=1) in the cycle after byte i+4 is sampled.
- Verdict pulse high during the cycle beginning 2 edges after the first edge sampling rx_data_valid=0.
- Back-to-back frames: IDLE accepts a new preamble on the cycle after CHECK; minimum 1 idle cycle between frames.
- Reset mid-frame: outputs 0 immediately, no verdict pulse; FIFO clears itself on its own reset.

## Configuration
- RX_ADDR_FILTER_EN defined: after destination byte 5 is sampled, compare bytes 0-5 with MAC_ADDRESS and 48'hFFFFFFFFFFFF. Mismatch: stop writes, pulse fifo_frame_bad next cycle, -> WAIT (no second pulse at frame end).
- Undefined: promiscuous; every frame passed to CHECK; MAC_ADDRESS ignored.

## Structure
- Shared package mac_pkg: CRC polynomial/seed, MIN_SIZE/MAX_SIZE defaults, preamble 8'h55, SFD 8'hD5, state encodings (WAIT, IDLE, PREAMBLE, DATA, CHECK).
- One sub-module: existing crc (DATA_WIDTH 8, CRC_WIDTH 32), init on SFD, enable on FIFO write.

## Test plan
- 64-byte frame (60 data + correct FCS), 7x55+D5 preamble -> 60 writes, start on first, fifo_frame_good once.
- Same frame, one FCS bit flipped -> 60 writes, fifo_frame_bad, no good.
- 40-byte frame with valid FCS -> bad (runt); 1519-byte frame -> bad.
- rx_error pulsed on byte 20; separately fifo_full held during byte 30 -> bad, no writes after overflow point.
- Reset release with rx_data_valid=1 mid-frame -> no writes, no pulses until next clean preamble, which then yields good.
- With RX_ADDR_FILTER_EN, MAC_ADDRESS=48'h02_00_00_00_00_01: matching, broadcast -> good; dest 02_00_00_00_00_02 -> bad after byte 5, no further writes.
